// File: rtl/bcd_pkg.sv
// Shared BCD constants and the per-digit validity helper.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  // True when a nibble is a legal decimal digit (0..9).
  function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One packed-BCD digit register: load, step up/down with wrap inside the digit.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             dir,     // 1 = up, 0 = down
  input  logic             load,
  input  logic [BCD_W-1:0] load_d,
  output logic [BCD_W-1:0] digit,
  output logic             at_max,
  output logic             at_min
);

  logic [BCD_W-1:0] digit_d, digit_q;

  assign digit  = digit_q;
  assign at_max = (digit_q == BCD_MAX);
  assign at_min = (digit_q == BCD_MIN);

  // Next digit: load wins over step; a stepping digit at a bound rolls to the other bound.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_d;
    end else if (step) begin
      if (dir) begin
        digit_d = at_max ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = at_min ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  // Digit state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/bcd_counter_multi.sv
// Multi-digit packed-BCD up/down counter with validated load, wrap/saturate and tc.
module bcd_counter_multi
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sel,
  input  logic                      load,
  input  logic [BCD_W*DIGITS-1:0]   load_val,
  output logic [BCD_W*DIGITS-1:0]   count,
  output logic                      tc,
  output logic                      load_err
);

  logic [DIGITS-1:0] at_max, at_min, step;
  logic              all_max, all_min, at_bound;
  logic              load_ok, do_load, count_en;
  logic              load_err_d, load_err_q;

  assign all_max  = &at_max;
  assign all_min  = &at_min;
  assign at_bound = sel ? all_max : all_min;

  // tc flags the step that would cross a bound, regardless of saturate mode.
  assign tc = ~rst & en & at_bound;

  // Load validation and the carry/borrow step-enable ripple.
  always_comb begin
    logic ripple;
    load_ok = 1'b1;
    ripple  = 1'b1;
    step    = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      load_ok = load_ok & is_bcd(load_val[BCD_W*i +: BCD_W]);
    end
    // Any load request, valid or not, suppresses counting this cycle.
    count_en = en & ~load & ~(SATURATE & at_bound);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      step[i] = count_en & ripple;
      ripple  = ripple & (sel ? at_max[i] : at_min[i]);
    end
    do_load    = load & load_ok;
    load_err_d = load & ~load_ok;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .step   (step[g]),
      .dir    (sel),
      .load   (do_load),
      .load_d (load_val[BCD_W*g +: BCD_W]),
      .digit  (count[BCD_W*g +: BCD_W]),
      .at_max (at_max[g]),
      .at_min (at_min[g])
    );
  end

  // Rejected-load pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Bench: three counter variants driven in lockstep, checked against an integer model.
module tb_bcd_counter_multi;

  logic        clk = 1'b0;
  logic        rst, en, sel, load;
  logic [7:0]  load_val8;
  logic [15:0] load_val16;
  logic [7:0]  count_w, count_s;
  logic [15:0] count_4;
  logic        tc_w, tc_s, tc_4;
  logic        err_w, err_s, err_4;

  int checks   = 0;
  int failures = 0;

  // Model state: 0 = 2-digit wrap, 1 = 2-digit saturate, 2 = 4-digit wrap.
  int mv[3];
  bit merr[3];
  int modulus[3] = '{100, 100, 10000};
  bit msat[3]    = '{1'b0, 1'b1, 1'b0};
  int ndig[3]    = '{2, 2, 4};

  always #5 clk = ~clk;

  bcd_counter_multi #(.DIGITS(2), .SATURATE(1'b0)) u_w (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .load(load), .load_val(load_val8),
    .count(count_w), .tc(tc_w), .load_err(err_w)
  );
  bcd_counter_multi #(.DIGITS(2), .SATURATE(1'b1)) u_s (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .load(load), .load_val(load_val8),
    .count(count_s), .tc(tc_s), .load_err(err_s)
  );
  bcd_counter_multi #(.DIGITS(4), .SATURATE(1'b0)) u_4 (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .load(load), .load_val(load_val16),
    .count(count_4), .tc(tc_4), .load_err(err_4)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] b, input int n);
    for (int k = 0; k < n; k++) if (b[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd_val(input logic [15:0] b, input int n);
    int r = 0;
    for (int k = n - 1; k >= 0; k--) r = r * 10 + int'(b[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] lv(input int i);
    return (i < 2) ? {8'h00, load_val8} : load_val16;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one rising edge, using the inputs held across it.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mv[i] = 0;
        merr[i] = 1'b0;
      end else if (load) begin
        if (bcd_ok(lv(i), ndig[i])) begin
          mv[i] = bcd_val(lv(i), ndig[i]);
          merr[i] = 1'b0;
        end else begin
          merr[i] = 1'b1;
        end
      end else begin
        merr[i] = 1'b0;
        if (en) begin
          if (sel) mv[i] = (mv[i] == modulus[i] - 1) ? (msat[i] ? mv[i] : 0) : mv[i] + 1;
          else mv[i] = (mv[i] == 0) ? (msat[i] ? 0 : modulus[i] - 1) : mv[i] - 1;
        end
      end
    end
  endtask

  function automatic bit exp_tc(input int i);
    return !rst && en && (sel ? (mv[i] == modulus[i] - 1) : (mv[i] == 0));
  endfunction

  // One cycle: check tc on settled inputs, clock, then check registered outputs.
  task automatic step();
    #1;
    check("tc_w", {15'd0, tc_w}, {15'd0, exp_tc(0)});
    check("tc_s", {15'd0, tc_s}, {15'd0, exp_tc(1)});
    check("tc_4", {15'd0, tc_4}, {15'd0, exp_tc(2)});
    @(posedge clk);
    model_edge();
    #1;
    check("count_w", {8'h00, count_w}, to_bcd(mv[0]));
    check("count_s", {8'h00, count_s}, to_bcd(mv[1]));
    check("count_4", count_4, to_bcd(mv[2]));
    check("err_w", {15'd0, err_w}, {15'd0, merr[0]});
    check("err_s", {15'd0, err_s}, {15'd0, merr[1]});
    check("err_4", {15'd0, err_4}, {15'd0, merr[2]});
  endtask

  task automatic drive(input bit r, input bit e, input bit s, input bit l,
                       input logic [7:0] v8, input logic [15:0] v16);
    rst = r; en = e; sel = s; load = l; load_val8 = v8; load_val16 = v16;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin mv[i] = 0; merr[i] = 1'b0; end
    drive(1, 1, 1, 0, 8'h00, 16'h0000);
    @(posedge clk);
    // Reset held with enable high.
    step(); step();
    // Count up through the full 2-digit range and wrap.
    drive(0, 1, 1, 0, 8'h00, 16'h0000);
    for (int n = 0; n < 100; n++) step();
    check("up_wrap_w", {8'h00, count_w}, 16'h0000);
    // Valid load, then an invalid load that must pulse load_err once.
    drive(0, 1, 1, 1, 8'h47, 16'h0047); step();
    check("load47", {8'h00, count_w}, 16'h0047);
    drive(0, 1, 1, 1, 8'h4A, 16'h004A); step();
    drive(0, 0, 1, 0, 8'h00, 16'h0000); step();
    // Borrow from 10 down through 00 into wrap/hold.
    drive(0, 0, 0, 1, 8'h10, 16'h0010); step();
    drive(0, 1, 0, 0, 8'h00, 16'h0000);
    for (int n = 0; n < 11; n++) step();
    check("down_wrap_w", {8'h00, count_w}, 16'h0099);
    check("down_hold_s", {8'h00, count_s}, 16'h0000);
    // Saturate at MAX going up.
    drive(0, 0, 1, 1, 8'h99, 16'h9999); step();
    drive(0, 1, 1, 0, 8'h00, 16'h0000);
    for (int n = 0; n < 3; n++) step();
    check("up_hold_s", {8'h00, count_s}, 16'h0099);
    // Reset coincident with load while counting.
    drive(0, 0, 1, 1, 8'h35, 16'h0035); step();
    drive(0, 1, 1, 0, 8'h00, 16'h0000); step();
    drive(1, 1, 1, 1, 8'h88, 16'h0088); step();
    check("rst_over_load", {8'h00, count_w}, 16'h0000);
    // Three-digit carry ripple on the 4-digit counter.
    drive(0, 0, 1, 1, 8'h09, 16'h0999); step();
    drive(0, 1, 1, 0, 8'h00, 16'h0000); step();
    check("ripple_4", count_4, 16'h1000);
    // Randomized phase, biased towards bound values and occasional bad digits.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] v;
      v = '0;
      for (int k = 0; k < 4; k++) begin
        v[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                    : ($urandom_range(0, 2) == 0) ? 4'(9 * $urandom_range(0, 1))
                    : 4'($urandom_range(0, 9));
      end
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0, v[7:0], v);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
